// File: rtl/cart_mem_arbiter_if.sv
// cart_mem_arbiter_if
//   SDRAM request/acknowledge bus between the cartridge memory arbiter and
//   the SDRAM controller.
//   master : arbiter side, drives the request, direction, address and write data.
//   slave  : controller side, returns the ack pulse and the read data.
//   Signals:
//     sdram_req  - request, held until sdram_ack
//     sdram_we   - 1 = write, 0 = read
//     sdram_addr - byte address (ADDR_W bits)
//     sdram_din  - write data
//     sdram_ack  - one-cycle completion pulse
//     sdram_dout - read data, valid with sdram_ack
interface cart_mem_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic              sdram_req;
    logic              sdram_we;
    logic [ADDR_W-1:0] sdram_addr;
    logic [7:0]        sdram_din;
    logic              sdram_ack;
    logic [7:0]        sdram_dout;

    modport master (
        output sdram_req, sdram_we, sdram_addr, sdram_din,
        input  sdram_ack, sdram_dout
    );

    modport slave (
        input  sdram_req, sdram_we, sdram_addr, sdram_din,
        output sdram_ack, sdram_dout
    );
endinterface

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter
//   Shares the single SDRAM port that holds cartridge ROM images between CPU
//   cartridge reads (already translated by the slot mappers) and ROM-image
//   writes from the loader. CPU offsets are relocated by a per-slot base
//   address; unmapped CPU reads are answered locally with FFh.
//   Ports:
//     clk, reset_n            - clock, asynchronous active-low reset
//     cpu_req/cart_num/mem_addr/mem_unmaped - CPU read pulse and its fields
//     cart_base0/cart_base1   - SDRAM base of each slot's image (static)
//     cpu_wait/cpu_data       - Z80 WAIT (combinational) and read data
//     ld_req/ld_addr/ld_data  - loader write pulse, absolute address, data
//     ld_ack                  - one-cycle pulse when the loader write is done
//     sdram                   - SDRAM bus (master side)
module cart_mem_arbiter #(
    parameter int ADDR_W = 25
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cart_num,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_unmaped,
    input  logic [ADDR_W-1:0]     cart_base0,
    input  logic [ADDR_W-1:0]     cart_base1,
    output logic                  cpu_wait,
    output logic [7:0]            cpu_data,
    input  logic                  ld_req,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [7:0]            ld_data,
    output logic                  ld_ack,
    cart_mem_arbiter_if.master    sdram
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LD  = 1'b1;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic              ld_pend_q, ld_pend_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [7:0]        ld_data_q, ld_data_d;
    logic [7:0]        cpu_data_q, cpu_data_d;
    logic              ld_ack_q, ld_ack_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;

    logic [ADDR_W-1:0] cpu_abs;
    logic              pick_ld;

    // Relocation wraps modulo 2^ADDR_W by truncation of the sum.
    assign cpu_abs = (cart_num ? cart_base1 : cart_base0) + mem_addr;

    // Round-robin: the CPU wins unless only the loader waits, or both wait
    // and the CPU was served last.
    assign pick_ld = !(cpu_pend_q && (!ld_pend_q || last_grant_q == GNT_LD));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cpu_pend_d   = cpu_pend_q;
        cpu_addr_d   = cpu_addr_q;
        ld_pend_d    = ld_pend_q;
        ld_addr_d    = ld_addr_q;
        ld_data_d    = ld_data_q;
        cpu_data_d   = cpu_data_q;
        ld_ack_d     = 1'b0;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        din_d        = din_q;

        // Requests landing on an already-set latch are dropped.
        if (cpu_req && !mem_unmaped && !cpu_pend_q) begin
            cpu_pend_d = 1'b1;
            cpu_addr_d = cpu_abs;
        end
        if (cpu_req && mem_unmaped)
            cpu_data_d = 8'hFF;
        if (ld_req && !ld_pend_q) begin
            ld_pend_d = 1'b1;
            ld_addr_d = ld_addr;
            ld_data_d = ld_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (cpu_pend_q || ld_pend_q) begin
                    grant_d      = pick_ld;
                    last_grant_d = pick_ld;
                    req_d        = 1'b1;
                    we_d         = pick_ld;
                    addr_d       = pick_ld ? ld_addr_q : cpu_addr_q;
                    din_d        = pick_ld ? ld_data_q : 8'h00;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (sdram.sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (grant_q == GNT_CPU) begin
                        cpu_data_d = sdram.sdram_dout;
                        cpu_pend_d = 1'b0;
                    end else begin
                        ld_pend_d = 1'b0;
                        ld_ack_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_CPU;
            last_grant_q <= GNT_LD;
            cpu_pend_q   <= 1'b0;
            cpu_addr_q   <= '0;
            ld_pend_q    <= 1'b0;
            ld_addr_q    <= '0;
            ld_data_q    <= 8'h00;
            cpu_data_q   <= 8'hFF;
            ld_ack_q     <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_addr_q   <= cpu_addr_d;
            ld_pend_q    <= ld_pend_d;
            ld_addr_q    <= ld_addr_d;
            ld_data_q    <= ld_data_d;
            cpu_data_q   <= cpu_data_d;
            ld_ack_q     <= ld_ack_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
        end
    end

    // WAIT must be valid in the request cycle itself, hence combinational.
    assign cpu_wait = (cpu_req & ~mem_unmaped) | cpu_pend_q;
    assign cpu_data = cpu_data_q;
    assign ld_ack   = ld_ack_q;

    assign sdram.sdram_req  = req_q;
    assign sdram.sdram_we   = we_q;
    assign sdram.sdram_addr = addr_q;
    assign sdram.sdram_din  = din_q;

endmodule
